pc_redirect_unit: RTL and testbench
===================================

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of cycles flush_o stays high after a redirect (legal range 1..7).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  system clock, all state on rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 ex_valid_i  in  1  EX-stage instruction is valid (not a bubble).
REQ-007 branch_i  in  1  EX instruction is a conditional branch.
REQ-008 jump_i  in  1  EX instruction is JAL/JALR (unconditional).
REQ-009 funct3_i  in  3  branch condition code of EX instruction.
REQ-010 BrEq_i  in  1  equality flag from branch comparator.
REQ-011 BrLT_i  in  1  less-than flag from branch comparator.
REQ-012 target_i  in  32  computed branch/jump target address.
REQ-013 imem_ready_i  in  1  instruction memory accepts current pc_o this cycle.
REQ-014 pc_o  out  32  fetch address.
REQ-015 pc_valid_o  out  1  pc_o is a valid fetch request.
REQ-016 redirect_o  out  1  one-cycle pulse: pc_o was just loaded from a taken branch/jump.
REQ-017 flush_o  out  1  kill IF/ID-stage instructions.
REQ-018 misalign_o  out  1  one-cycle pulse: taken target had target_i[1:0] != 0.
REQ-019 illegal_o  out  1  one-cycle pulse: valid branch with funct3_i 010 or 011.
REQ-020 redirect_cnt_o  out  16  saturating count of performed redirects.

Function
REQ-021 cond SHALL be: 000 BrEq_i; 001 !BrEq_i; 100/110 BrLT_i; 101/111 !BrLT_i; 010/011 0.
REQ-022 taken SHALL equal ex_valid_i & (jump_i | (branch_i & cond)) & state==RUN; jump_i has priority over branch_i.
REQ-023 States SHALL be RUN and FLUSH; reset enters RUN.
REQ-024 RUN, taken and target_i[1:0]==0: next cycle pc_o=target_i, redirect_o=1, redirect_cnt_o+1, state FLUSH, flush counter loaded with FLUSH_CYCLES.
REQ-025 RUN, taken and target_i[1:0]!=0: no redirect; misalign_o=1 next cycle; pc_o follows sequential rule.
REQ-026 Not redirecting: pc_o SHALL advance by 4 when imem_ready_i=1, hold otherwise; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-027 Redirect SHALL take effect regardless of imem_ready_i.
REQ-028 FLUSH: flush_o=1; counter decrements each cycle; at 1 return to RUN (flush_o high exactly FLUSH_CYCLES cycles); branch/jump inputs ignored; sequential PC advance continues.
REQ-029 illegal_o SHALL pulse one cycle after ex_valid_i & branch_i & !jump_i & funct3_i in {010,011} in RUN.
REQ-030 redirect_cnt_o SHALL saturate at 16'hFFFF.
REQ-031 pc_valid_o SHALL be 0 during reset and 1 from the first rising edge after rst_i deasserts.

Reset
REQ-032 On rst_i=1, immediately: pc_o=RESET_PC, pc_valid_o=0, redirect_o=0, flush_o=0, misalign_o=0, illegal_o=0, redirect_cnt_o=0, state RUN, flush counter 0.
REQ-033 rst_i asserted during FLUSH SHALL abort the flush with flush_o=0 the same instant.

Verification
REQ-034 Reset release, imem_ready_i=1 for 4 cycles -> pc_o 0,4,8,C,10; pc_valid_o=1.
REQ-035 pc_o=0x20, BEQ, BrEq_i=1, target 0x100 -> next cycle pc_o=0x100, redirect_o=1, flush_o high 2 cycles, redirect_cnt_o=1.
REQ-036 BGEU, BrLT_i=1 -> not taken, pc_o+4; then BNE during FLUSH with BrEq_i=0 -> ignored.
REQ-037 JAL, target 0x102 -> misalign_o pulse, no redirect; funct3=010 branch -> illegal_o pulse.
REQ-038 pc_o=0xFFFF_FFFC, imem_ready_i=1 -> pc_o=0; imem_ready_i=0 for 3 cycles -> pc_o held; redirect during stall -> pc_o loads target.
REQ-039 rst_i pulsed mid-FLUSH -> flush_o=0, pc_o=RESET_PC asynchronously.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
//
// Fetch-address generator with EX-stage branch/jump redirection. The PC
// advances sequentially by 4 whenever instruction memory accepts the current
// address. A taken, word-aligned branch or jump reloads the PC from target_i.
// After a redirect a flush window is opened that kills the wrong-path IF/ID
// instructions for FLUSH_CYCLES cycles. While that window is open, further
// branch/jump requests are ignored.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//   FLUSH_CYCLES  cycles flush_o stays high after a redirect (1..7)
//
// Ports
//   clk_i           in   system clock, rising edge
//   rst_i           in   asynchronous active-high reset
//   ex_valid_i      in   EX-stage instruction is valid
//   branch_i        in   EX instruction is a conditional branch
//   jump_i          in   EX instruction is JAL/JALR
//   funct3_i        in   branch condition code
//   BrEq_i          in   comparator equality flag
//   BrLT_i          in   comparator less-than flag
//   target_i        in   computed branch/jump target
//   imem_ready_i    in   instruction memory accepts pc_o this cycle
//   pc_o            out  fetch address
//   pc_valid_o      out  pc_o is a valid fetch request
//   redirect_o      out  pulse: pc_o was just loaded from a taken target
//   flush_o         out  kill IF/ID-stage instructions
//   misalign_o      out  pulse: taken target was not word aligned
//   illegal_o       out  pulse: branch with reserved funct3 (010/011)
//   redirect_cnt_o  out  saturating count of performed redirects
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic [2:0]  funct3_i,
    input  logic        BrEq_i,
    input  logic        BrLT_i,
    input  logic [31:0] target_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        redirect_o,
    output logic        flush_o,
    output logic        misalign_o,
    output logic        illegal_o,
    output logic [15:0] redirect_cnt_o
);

    localparam logic [0:0] STATE_RUN   = 1'b0;
    localparam logic [0:0] STATE_FLUSH = 1'b1;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    // Saturating increment for the redirect counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end
        return val + 16'd1;
    endfunction

    logic [0:0]  state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic        redirect_q, redirect_d;
    logic        misalign_q, misalign_d;
    logic        illegal_q, illegal_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;

    logic        cond;
    logic        in_run;
    logic        taken;
    logic        target_aligned;
    logic        do_redirect;
    logic [31:0] pc_seq;

    always_comb begin
        cond = 1'b0;
        case (funct3_i)
            3'b000:         cond = BrEq_i;
            3'b001:         cond = !BrEq_i;
            3'b100, 3'b110: cond = BrLT_i;
            3'b101, 3'b111: cond = !BrLT_i;
            default:        cond = 1'b0;   // 010/011 are reserved, never taken
        endcase

        in_run         = (state_q == STATE_RUN);
        // A jump is taken irrespective of the branch flag and condition.
        taken          = ex_valid_i & (jump_i | (branch_i & cond)) & in_run;
        target_aligned = (target_i[1:0] == 2'b00);
        do_redirect    = taken & target_aligned;

        // 32-bit add wraps 0xFFFF_FFFC back to 0 on its own.
        pc_seq = imem_ready_i ? (pc_q + 32'd4) : pc_q;
        // Redirect wins even when memory is stalled.
        pc_d   = do_redirect ? target_i : pc_seq;

        pc_valid_d     = 1'b1;
        redirect_d     = do_redirect;
        misalign_d     = taken & !target_aligned;
        illegal_d      = ex_valid_i & branch_i & !jump_i &
                         (funct3_i[2:1] == 2'b01) & in_run;
        redirect_cnt_d = do_redirect ? sat_inc16(redirect_cnt_q) : redirect_cnt_q;

        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (in_run) begin
            if (do_redirect) begin
                state_d     = STATE_FLUSH;
                flush_cnt_d = FLUSH_LOAD;
            end
        end else begin
            // Leaving on a count of 1 keeps flush_o high exactly FLUSH_CYCLES cycles.
            if (flush_cnt_q <= 3'd1) begin
                state_d     = STATE_RUN;
                flush_cnt_d = 3'd0;
            end else begin
                flush_cnt_d = flush_cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= STATE_RUN;
            flush_cnt_q    <= 3'd0;
            pc_q           <= RESET_PC;
            pc_valid_q     <= 1'b0;
            redirect_q     <= 1'b0;
            misalign_q     <= 1'b0;
            illegal_q      <= 1'b0;
            redirect_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            pc_q           <= pc_d;
            pc_valid_q     <= pc_valid_d;
            redirect_q     <= redirect_d;
            misalign_q     <= misalign_d;
            illegal_q      <= illegal_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign pc_o           = pc_q;
    assign pc_valid_o     = pc_valid_q;
    assign redirect_o     = redirect_q;
    // Derived from state so that reset drops it the same instant.
    assign flush_o        = (state_q == STATE_FLUSH);
    assign misalign_o     = misalign_q;
    assign illegal_o      = illegal_q;
    assign redirect_cnt_o = redirect_cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic        br_eq;
    logic        br_lt;
    logic [31:0] target;
    logic        imem_ready;
    logic [31:0] pc;
    logic        pc_valid;
    logic        redirect;
    logic        flush;
    logic        misalign;
    logic        illegal;
    logic [15:0] redirect_cnt;

    int checks = 0;
    int errors = 0;

    pc_redirect_unit #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ex_valid_i    (ex_valid),
        .branch_i      (branch),
        .jump_i        (jump),
        .funct3_i      (funct3),
        .BrEq_i        (br_eq),
        .BrLT_i        (br_lt),
        .target_i      (target),
        .imem_ready_i  (imem_ready),
        .pc_o          (pc),
        .pc_valid_o    (pc_valid),
        .redirect_o    (redirect),
        .flush_o       (flush),
        .misalign_o    (misalign),
        .illegal_o     (illegal),
        .redirect_cnt_o(redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic        br;
        logic        jp;
        logic [2:0]  f3;
        logic        eq;
        logic        lt;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] e_pc;
        logic        e_redir;
        logic        e_flush;
        logic        e_mis;
        logic        e_ill;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ev, input logic br, input logic jp, input logic [2:0] f3,
                       input logic eq, input logic lt, input logic [31:0] tgt, input logic rdy,
                       input logic [31:0] e_pc, input logic e_redir, input logic e_flush,
                       input logic e_mis, input logic e_ill, input logic [15:0] e_cnt);
        vec_t v;
        v.ev = ev; v.br = br; v.jp = jp; v.f3 = f3; v.eq = eq; v.lt = lt;
        v.tgt = tgt; v.rdy = rdy; v.e_pc = e_pc; v.e_redir = e_redir;
        v.e_flush = e_flush; v.e_mis = e_mis; v.e_ill = e_ill; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic br, input logic jp, input logic [2:0] f3,
                         input logic eq, input logic lt, input logic [31:0] tgt, input logic rdy);
        ex_valid = ev; branch = br; jump = jp; funct3 = f3;
        br_eq = eq; br_lt = lt; target = tgt; imem_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_redir, input logic e_flush, input logic e_mis,
                             input logic e_ill, input logic [15:0] e_cnt);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e_valid});
        check({tag, ".redirect"}, {31'd0, redirect}, {31'd0, e_redir});
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
        check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
        check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e_ill});
        check({tag, ".cnt"}, {16'd0, redirect_cnt}, {16'd0, e_cnt});
    endtask

    initial begin
        // ev br jp f3 eq lt tgt rdy | pc redir flush mis ill cnt
        add(0,0,0,3'b000,0,0,32'h0,   0, 32'h0,    0,0,0,0,16'd0); // first edge, stalled
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h4,    0,0,0,0,16'd0);
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h8,    0,0,0,0,16'd0);
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'hC,    0,0,0,0,16'd0);
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h10,   0,0,0,0,16'd0);
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h14,   0,0,0,0,16'd0);
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h18,   0,0,0,0,16'd0);
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h1C,   0,0,0,0,16'd0);
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h20,   0,0,0,0,16'd0);
        add(1,1,0,3'b000,1,0,32'h100, 1, 32'h100,  1,1,0,0,16'd1); // BEQ taken
        add(1,1,0,3'b001,0,0,32'h200, 1, 32'h104,  0,1,0,0,16'd1); // BNE in FLUSH ignored
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h108,  0,0,0,0,16'd1);
        add(1,1,0,3'b111,0,1,32'h300, 1, 32'h10C,  0,0,0,0,16'd1); // BGEU, LT -> not taken
        add(1,0,1,3'b000,0,0,32'h102, 1, 32'h110,  0,0,1,0,16'd1); // JAL misaligned
        add(1,1,0,3'b010,1,0,32'h400, 1, 32'h114,  0,0,0,1,16'd1); // reserved funct3
        add(0,0,0,3'b000,0,0,32'h0,   0, 32'h114,  0,0,0,0,16'd1); // stall
        add(1,1,0,3'b100,0,1,32'h40,  0, 32'h40,   1,1,0,0,16'd2); // BLT during stall
        add(0,0,0,3'b000,0,0,32'h0,   0, 32'h40,   0,1,0,0,16'd2);
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h44,   0,0,0,0,16'd2);
        add(1,1,1,3'b010,0,0,32'h80,  1, 32'h80,   1,1,0,0,16'd3); // jump beats branch
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h84,   0,1,0,0,16'd3);
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h88,   0,0,0,0,16'd3);
        add(0,0,1,3'b000,0,0,32'h300, 1, 32'h8C,   0,0,0,0,16'd3); // bubble jump
        add(1,1,0,3'b001,1,0,32'h500, 1, 32'h90,   0,0,0,0,16'd3); // BNE equal -> not taken
        add(1,1,0,3'b101,0,0,32'h1000,1, 32'h1000, 1,1,0,0,16'd4); // BGE taken
        add(1,1,0,3'b110,0,1,32'h6,   1, 32'h1004, 0,1,0,0,16'd4); // misaligned branch ignored in FLUSH
        add(1,1,0,3'b110,0,1,32'h6,   1, 32'h1008, 0,0,0,0,16'd4);
        add(1,1,0,3'b110,0,1,32'h6,   1, 32'h100C, 0,0,1,0,16'd4); // BLTU misaligned in RUN
        add(0,0,0,3'b000,0,0,32'h0,   1, 32'h1010, 0,0,0,0,16'd4);

        rst = 1'b1;
        drive(0,0,0,3'b000,0,0,32'h0,1);
        #12;
        check_all("reset", 32'h0, 0, 0, 0, 0, 0, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ev, vecs[i].br, vecs[i].jp, vecs[i].f3,
                  vecs[i].eq, vecs[i].lt, vecs[i].tgt, vecs[i].rdy);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, 1'b1, vecs[i].e_redir,
                      vecs[i].e_flush, vecs[i].e_mis, vecs[i].e_ill, vecs[i].e_cnt);
        end

        // Wrap from the top of the address space, then hold under stall.
        drive(1,0,1,3'b000,0,0,32'hFFFF_FFFC,0);
        step();
        check_all("wrap_jump", 32'hFFFF_FFFC, 1, 1, 1, 0, 0, 16'd5);
        drive(0,0,0,3'b000,0,0,32'h0,0);
        step();
        check_all("wrap_fl1", 32'hFFFF_FFFC, 1, 0, 1, 0, 0, 16'd5);
        step();
        check_all("wrap_fl2", 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 16'd5);
        drive(0,0,0,3'b000,0,0,32'h0,1);
        step();
        check_all("wrap", 32'h0, 1, 0, 0, 0, 0, 16'd5);
        drive(0,0,0,3'b000,0,0,32'h0,0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("hold%0d", i), 32'h0, 1, 0, 0, 0, 0, 16'd5);
        end

        // Asynchronous reset in the middle of a flush window.
        drive(1,0,1,3'b000,0,0,32'h500,1);
        step();
        check_all("pre_rst", 32'h500, 1, 1, 1, 0, 0, 16'd6);
        drive(0,0,0,3'b000,0,0,32'h0,1);
        #2;
        rst = 1'b1;
        #1;
        check_all("mid_rst", 32'h0, 0, 0, 0, 0, 0, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0,0,0,3'b000,0,0,32'h0,0);
        step();
        check_all("post_rst", 32'h0, 1, 0, 0, 0, 0, 16'd0);
        drive(0,0,0,3'b000,0,0,32'h0,1);
        step();
        check_all("post_rst_adv", 32'h4, 1, 0, 0, 0, 0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
